// File: rtl/mcif_rd_dma_client.sv
// Per-client MCIF read DMA front end: splits one command into bursts and streams the returned beats to the client.
// Define MCIF_RD_4K_SPLIT_EN to also clip bursts so they never cross a 4 KB address boundary.
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 128
`endif
`ifndef log2MAX_BURST_ATOM_CUBE
`define log2MAX_BURST_ATOM_CUBE 4
`endif

module mcif_rd_dma_client #(
   parameter int CNT_WIDTH  = 24,
   parameter int ATOM_BYTES = `AXI_DATA_WIDTH / 8,
   parameter int LEN_W      = `log2MAX_BURST_ATOM_CUBE
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       cmd_vld,
   output logic                       cmd_rdy,
   input  logic [31:0]                cmd_addr,
   input  logic [CNT_WIDTH-1:0]       cmd_atoms,
   output logic                       rd_req_vld,
   input  logic                       rd_req_rdy,
   output logic [LEN_W+31:0]          rd_req_pd,
   input  logic                       rd_resp_vld,
   output logic                       rd_resp_rdy,
   input  logic [`AXI_DATA_WIDTH-1:0] rd_resp_pd,
   output logic                       rd_fifo_pop,
   output logic                       out_vld,
   input  logic                       out_rdy,
   output logic [`AXI_DATA_WIDTH-1:0] out_pd,
   output logic                       busy,
   output logic                       done
);

   localparam int ATOM_SHIFT = $clog2(ATOM_BYTES);
   localparam int MW0        = (CNT_WIDTH > 13) ? CNT_WIDTH : 13;
   localparam int MW         = (MW0 > LEN_W + 1) ? MW0 : LEN_W + 1;
   localparam logic [MW-1:0] MAX_BURST  = MW'(1) << LEN_W;
   localparam logic [31:0]   ALIGN_MASK = 32'(ATOM_BYTES - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

   state_e                 state_q, state_d;
   logic [31:0]            cur_addr_q, cur_addr_d;
   logic [CNT_WIDTH-1:0]   req_left_q, req_left_d;
   logic [CNT_WIDTH-1:0]   beat_left_q, beat_left_d;
   logic                   req_vld_q, req_vld_d;
   logic [LEN_W+31:0]      req_pd_q, req_pd_d;

   logic                   cmd_hs;
   logic                   beat_hs;
   logic                   can_load;
   logic                   load;
   logic [31:0]            burst_addr;
   logic [CNT_WIDTH-1:0]   burst_left;
   logic [MW-1:0]          burst;
`ifdef MCIF_RD_4K_SPLIT_EN
   logic [12:0]            to_4k;
`endif

   // Response path is a pure pass-through; only the credit count is tapped off it.
   assign out_vld     = rd_resp_vld;
   assign out_pd      = rd_resp_pd;
   assign rd_resp_rdy = out_rdy;
   assign rd_fifo_pop = rd_resp_vld & out_rdy;
   assign beat_hs     = rd_fifo_pop;

   assign cmd_rdy    = rst_n & (state_q == IDLE);
   assign cmd_hs     = cmd_vld & cmd_rdy;
   assign busy       = (state_q != IDLE);
   assign done       = (state_q == DONE);
   assign rd_req_vld = req_vld_q;
   assign rd_req_pd  = req_pd_q;

   // The first burst is loaded straight from the command so the request appears one cycle after acceptance.
   assign can_load = ~req_vld_q | rd_req_rdy;
   assign load     = ((state_q == IDLE) && cmd_hs && (cmd_atoms != '0)) ||
                     ((state_q == ISSUE) && can_load && (req_left_q != '0));

   always_comb begin
      burst_addr = (state_q == IDLE) ? (cmd_addr & ~ALIGN_MASK) : cur_addr_q;
      burst_left = (state_q == IDLE) ? cmd_atoms : req_left_q;
      burst      = MW'(burst_left);
      if (burst > MAX_BURST) burst = MAX_BURST;
`ifdef MCIF_RD_4K_SPLIT_EN
      to_4k = (13'h1000 - {1'b0, burst_addr[11:0]}) >> ATOM_SHIFT;
      if (burst > MW'(to_4k)) burst = MW'(to_4k);
`endif
   end

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d     = state_q;
      cur_addr_d  = cur_addr_q;
      req_left_d  = req_left_q;
      beat_left_d = beat_left_q;
      req_vld_d   = req_vld_q;
      req_pd_d    = req_pd_q;

      if (beat_hs && (state_q == ISSUE || state_q == WAIT) && (beat_left_q != '0))
         beat_left_d = beat_left_q - CNT_WIDTH'(1);

      if (load) begin
         req_vld_d  = 1'b1;
         req_pd_d   = {LEN_W'(burst - MW'(1)), burst_addr};
         cur_addr_d = burst_addr + (32'(burst) << ATOM_SHIFT);
         req_left_d = burst_left - CNT_WIDTH'(burst);
      end else if (state_q == ISSUE && can_load) begin
         req_vld_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (cmd_hs) begin
               beat_left_d = cmd_atoms;
               state_d     = (cmd_atoms == '0) ? DONE : ISSUE;
            end
         end
         ISSUE: begin
            if (can_load && (req_left_q == '0))
               state_d = (beat_left_d == '0) ? DONE : WAIT;
         end
         WAIT: begin
            if (beat_left_d == '0) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cur_addr_q  <= '0;
         req_left_q  <= '0;
         beat_left_q <= '0;
         req_vld_q   <= 1'b0;
         req_pd_q    <= '0;
      end else begin
         state_q     <= state_d;
         cur_addr_q  <= cur_addr_d;
         req_left_q  <= req_left_d;
         beat_left_q <= beat_left_d;
         req_vld_q   <= req_vld_d;
         req_pd_q    <= req_pd_d;
      end
   end

endmodule

// File: tb/tb_mcif_rd_dma_client.sv
// Randomized scoreboard bench for mcif_rd_dma_client: a burst-splitting model feeds an expected-request queue.
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 128
`endif
`ifndef log2MAX_BURST_ATOM_CUBE
`define log2MAX_BURST_ATOM_CUBE 4
`endif

module tb_mcif_rd_dma_client;

   localparam int AW   = `AXI_DATA_WIDTH;
   localparam int LW   = `log2MAX_BURST_ATOM_CUBE;
   localparam int AB   = AW / 8;
   localparam int CW   = 24;
   localparam int MAXB = 1 << LW;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            cmd_vld;
   logic            cmd_rdy;
   logic [31:0]     cmd_addr;
   logic [CW-1:0]   cmd_atoms;
   logic            rd_req_vld;
   logic            rd_req_rdy;
   logic [LW+31:0]  rd_req_pd;
   logic            rd_resp_vld;
   logic            rd_resp_rdy;
   logic [AW-1:0]   rd_resp_pd;
   logic            rd_fifo_pop;
   logic            out_vld;
   logic            out_rdy;
   logic [AW-1:0]   out_pd;
   logic            busy;
   logic            done;

   mcif_rd_dma_client #(.CNT_WIDTH(CW), .ATOM_BYTES(AB), .LEN_W(LW)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_addr(cmd_addr), .cmd_atoms(cmd_atoms),
      .rd_req_vld(rd_req_vld), .rd_req_rdy(rd_req_rdy), .rd_req_pd(rd_req_pd),
      .rd_resp_vld(rd_resp_vld), .rd_resp_rdy(rd_resp_rdy), .rd_resp_pd(rd_resp_pd),
      .rd_fifo_pop(rd_fifo_pop), .out_vld(out_vld), .out_rdy(out_rdy), .out_pd(out_pd),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int cycle = 0;
   int exp_done_cycle = -1;
   int exp_first_req = 1 << 30;
   int cur_atoms = 0;
   int beats_seen = 0;
   int beats_pending = 0;
   int req_rdy_mode = 0;
   int out_rdy_mode = 0;
   int stall_cnt = 0;
   bit cmd_active = 1'b0;
   bit spur_req = 1'b0;
   bit prev_stall = 1'b0;
   logic [LW+31:0] prev_pd = '0;
   logic [LW+31:0] exp_req_q[$];

   task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   task automatic summary_and_finish();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   endtask

   task automatic timeout(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s: DUT event did not occur within the cycle budget (cycle %0d)", name, cycle);
      summary_and_finish();
   endtask

   // Reference: greedy split into bursts capped at MAXB atoms (and at the 4 KB page end when enabled).
   task automatic push_model(input logic [31:0] addr, input int atoms);
      longint a;
      int left;
      int b;
      a = longint'(addr & ~32'(AB - 1));
      left = atoms;
      while (left > 0) begin
         b = (left < MAXB) ? left : MAXB;
`ifdef MCIF_RD_4K_SPLIT_EN
         begin
            int to4k;
            to4k = (4096 - int'(a % 4096)) / AB;
            if (b > to4k) b = to4k;
         end
`endif
         exp_req_q.push_back({LW'(b - 1), a[31:0]});
         a = (a + longint'(b) * AB) % (longint'(1) << 32);
         left -= b;
      end
   endtask

   task automatic start_cmd(input logic [31:0] addr, input int atoms);
      bit ok;
      push_model(addr, atoms);
      @(posedge clk); #1;
      cmd_vld = 1'b1;
      cmd_addr = addr;
      cmd_atoms = CW'(atoms);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (cmd_rdy) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) timeout("cmd_accept");
      cmd_active = 1'b1;
      cur_atoms = atoms;
      beats_seen = 0;
      exp_first_req = cycle + 1;
      exp_done_cycle = (atoms == 0) ? cycle + 1 : -1;
      @(posedge clk); #1;
      cmd_vld = 1'b0;
      cmd_addr = $urandom;
      cmd_atoms = CW'($urandom);
   endtask

   task automatic run_cmd(input logic [31:0] addr, input int atoms, input int rmode, input int omode);
      bit ok;
      req_rdy_mode = rmode;
      out_rdy_mode = omode;
      stall_cnt = 0;
      start_cmd(addr, atoms);
      @(negedge clk);
      check("busy_after_cmd", busy, 1'b1);
      check("cmd_rdy_busy", cmd_rdy, 1'b0);
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (done) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) timeout("done_wait");
      @(negedge clk);
      check("busy_after_done", busy, 1'b0);
      check("cmd_rdy_after_done", cmd_rdy, 1'b1);
      check("req_remaining", exp_req_q.size(), 0);
      check("beats_remaining", beats_pending, 0);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         cycle++;
      end
   end

   // Memory-side responder: request ready per mode, one beat per requested atom, random client ready.
   initial begin
      bit accepted;
      rd_req_rdy = 1'b0;
      rd_resp_vld = 1'b0;
      rd_resp_pd = '0;
      out_rdy = 1'b0;
      forever begin
         @(posedge clk);
         accepted = rd_resp_vld && out_rdy;
         #1;
         if (!rst_n) begin
            rd_resp_vld = 1'b0;
            rd_req_rdy = 1'b0;
            out_rdy = 1'b0;
         end else begin
            if (spur_req || ((!rd_resp_vld || accepted) && beats_pending > 0 && $urandom_range(0, 3) != 0)) begin
               rd_resp_vld = 1'b1;
               for (int k = 0; k < AW / 32; k++) rd_resp_pd[k*32 +: 32] = $urandom;
            end else if (!rd_resp_vld || accepted) begin
               rd_resp_vld = 1'b0;
            end
            out_rdy = (out_rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
            case (req_rdy_mode)
               0: rd_req_rdy = 1'b1;
               1: rd_req_rdy = ($urandom_range(0, 2) != 0);
               default: begin
                  if (rd_req_vld && stall_cnt < 5) begin
                     rd_req_rdy = 1'b0;
                     stall_cnt++;
                  end else begin
                     rd_req_rdy = 1'b1;
                  end
               end
            endcase
         end
      end
   end

   // Monitor: pops expected requests on each handshake and checks pass-through, credits and done timing.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (prev_stall) begin
               check("req_hold_vld", rd_req_vld, 1'b1);
               check("req_hold_pd", rd_req_pd, prev_pd);
            end
            prev_stall = rd_req_vld && !rd_req_rdy;
            prev_pd = rd_req_pd;
            if (rd_req_vld && rd_req_rdy) begin
               if (exp_req_q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL req_extra: got request pd %h, expected no request (cycle %0d)", rd_req_pd, cycle);
               end else begin
                  check("req_pd", rd_req_pd, exp_req_q.pop_front());
                  beats_pending += int'(rd_req_pd[LW+31:32]) + 1;
               end
            end
            if (req_rdy_mode == 0 && cmd_active && cycle >= exp_first_req && exp_req_q.size() > 0)
               check("req_b2b_vld", rd_req_vld, 1'b1);
            check("out_vld", out_vld, rd_resp_vld);
            check("rd_resp_rdy", rd_resp_rdy, out_rdy);
            check("rd_fifo_pop", rd_fifo_pop, rd_resp_vld & out_rdy);
            if (rd_resp_vld) check("out_pd", out_pd, rd_resp_pd);
            check("done", done, cycle == exp_done_cycle);
            if (done) begin
               check("busy_in_done", busy, 1'b1);
               cmd_active = 1'b0;
            end
            if (rd_resp_vld && out_rdy) begin
               if (beats_pending > 0) beats_pending--;
               if (cmd_active) begin
                  beats_seen++;
                  if (beats_seen == cur_atoms) exp_done_cycle = cycle + 1;
               end
            end
         end else begin
            prev_stall = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      timeout("global_watchdog");
   end

   initial begin
      bit ok;
      rst_n = 1'b0;
      cmd_vld = 1'b0;
      cmd_addr = '0;
      cmd_atoms = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_cmd_rdy", cmd_rdy, 1'b0);
      check("rst_req_vld", rd_req_vld, 1'b0);
      check("rst_req_pd", rd_req_pd, '0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_cmd_rdy", cmd_rdy, 1'b1);

      run_cmd(32'h0000_1000, 40, 0, 0);
      run_cmd(32'h0000_0FE0, 8, 0, 0);
      run_cmd(32'h0000_0FE7, 8, 0, 0);
      run_cmd(32'h0000_3000, 40, 2, 0);
      run_cmd(32'h0000_4000, 24, 0, 1);
      run_cmd(32'h0000_0100, 0, 0, 0);
      run_cmd(32'hFFFF_FFC0, 20, 1, 1);

      out_rdy_mode = 0;
      @(posedge clk); #2;
      spur_req = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      spur_req = 1'b0;
      repeat (2) @(posedge clk);
      run_cmd(32'h0000_6040, 17, 0, 0);

      for (int i = 0; i < 20; i++) begin
         logic [31:0] r;
         r = $urandom;
         if (i % 2 == 1) r = r | 32'h0000_0F00;
         run_cmd(r, int'($urandom_range(0, 70)), int'($urandom_range(0, 2)), int'($urandom_range(0, 1)));
      end

      req_rdy_mode = 0;
      out_rdy_mode = 0;
      start_cmd(32'h0000_2000, 40);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk); #1;
         if (exp_req_q.size() == 1) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) timeout("second_burst");
      @(posedge clk); #2;
      rst_n = 1'b0;
      exp_req_q.delete();
      beats_pending = 0;
      cmd_active = 1'b0;
      exp_done_cycle = -1;
      @(negedge clk);
      check("midrst_req_vld", rd_req_vld, 1'b0);
      check("midrst_busy", busy, 1'b0);
      check("midrst_cmd_rdy", cmd_rdy, 1'b0);
      check("midrst_done", done, 1'b0);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(negedge clk);
      check("postrst_cmd_rdy", cmd_rdy, 1'b1);
      check("postrst_busy", busy, 1'b0);
      check("postrst_req_vld", rd_req_vld, 1'b0);
      run_cmd(32'h0000_5000, 20, 0, 0);

      repeat (3) @(negedge clk);
      summary_and_finish();
   end

endmodule

// File: doc/mcif_rd_dma_client.md
# mcif_rd_dma_client

Per-client read DMA front end for the MCIF read path. It accepts one transfer command (start address, atom count) and splits it into AXI-legal bursts on the `rd_req` interface of one MCIF read port. It forwards that port's returned data beats to the client and returns one credit per beat the client consumes via `rd_fifo_pop`. It signals completion when every beat of the command has been delivered. One instance sits directly upstream of each MCIF read port.

## Interface
Parameters:
- `CNT_WIDTH`, 24: width of the command atom count.
- `ATOM_BYTES`, `` `AXI_DATA_WIDTH/8 ``: bytes per atom (one AXI beat); must be a power of two.
- `LEN_W`, `` `log2MAX_BURST_ATOM_CUBE ``: width of the burst-length field. Maximum burst is 2^LEN_W atoms.

Ports (reset is asynchronous, active-low):
- `clk` input 1: the single clock for the block.
- `rst_n` input 1: asynchronous active-low reset.
- `cmd_vld` input 1: transfer command valid.
- `cmd_rdy` output 1: command accepted in IDLE only.
- `cmd_addr` input 32: start byte address; low log2(ATOM_BYTES) bits are ignored and forced to 0.
- `cmd_atoms` input CNT_WIDTH: number of atoms to read; 0 is legal.
- `rd_req_vld` output 1: burst request valid, to MCIF.
- `rd_req_rdy` input 1: burst request ready, from MCIF.
- `rd_req_pd` output LEN_W+32: `{len_m1[LEN_W-1:0], addr[31:0]}`, where len_m1 = atoms-1.
- `rd_resp_vld` input 1: response beat valid, from MCIF.
- `rd_resp_rdy` output 1: response beat ready, to MCIF; equals `out_rdy`.
- `rd_resp_pd` input `` `AXI_DATA_WIDTH ``: response data beat.
- `rd_fifo_pop` output 1: credit return, one pulse per beat consumed.
- `out_vld` output 1: data beat valid to client; equals `rd_resp_vld`.
- `out_rdy` input 1: client ready.
- `out_pd` output `` `AXI_DATA_WIDTH ``: data to client; equals `rd_resp_pd`.
- `busy` output 1: high in every state other than IDLE.
- `done` output 1: one-cycle pulse when the command completes.

## Operation
- States:
  - IDLE: `cmd_rdy`=1. On `cmd_vld`, latch `cur_addr`, `req_left`=`cmd_atoms`, `beat_left`=`cmd_atoms`. Go to ISSUE, or to DONE if `cmd_atoms`==0.
  - ISSUE: drive burst requests until `req_left`==0, then go to WAIT.
  - WAIT: all requests issued; wait for `beat_left`==0, then go to DONE.
  - DONE: `done`=1 for one cycle, then go to IDLE.
- Burst size: burst = min(`req_left`, 2^LEN_W, `atoms_to_4k`), where `atoms_to_4k` = (4096 − `cur_addr[11:0]`)/ATOM_BYTES, computed 13 bits wide.
- On each `rd_req` handshake:
  - `cur_addr` += burst*ATOM_BYTES (32-bit wrap, no error).
  - `req_left` −= burst.
- Data path is combinational pass-through: `out_vld`=`rd_resp_vld`, `out_pd`=`rd_resp_pd`, `rd_resp_rdy`=`out_rdy`.
- `rd_fifo_pop` = `rd_resp_vld & out_rdy`, combinational, same cycle as the beat handshake.
- `beat_left` decrements on each beat handshake in ISSUE or WAIT. Beats can arrive while requests are still being issued.
- Beats arriving in IDLE or DONE are spurious. They are still passed through and popped, and `beat_left` saturates at 0.
- `req_left` and `beat_left` are CNT_WIDTH bits wide. A command never wraps the counters.

## Timing
- Reset values:
  - `cmd_rdy`=0 during reset, then 1 in IDLE.
  - `rd_req_vld`=0, `rd_req_pd`=0, `busy`=0, `done`=0, state=IDLE.
  - `rd_fifo_pop`, `out_vld`, `rd_resp_rdy` follow their inputs.
- `rd_req_vld` and `rd_req_pd` are registered.
- First `rd_req_vld` rises 1 cycle after the command handshake.
- Back-to-back bursts are required: 1 request per cycle while `rd_req_rdy`=1.
- Handshake rules:
  - `rd_req_pd` holds stable while `rd_req_vld`=1 and `rd_req_rdy`=0.
  - `rd_req_vld` never drops without a handshake.
- `done` pulses exactly 1 cycle after the cycle in which the last beat is accepted. For `cmd_atoms`=0, `done` pulses 1 cycle after the command handshake.
- A new command can be accepted the cycle after `done`.
- Reset asserted mid-operation: all state clears immediately. Outstanding AXI beats are not tracked; the reset is system-wide.

## Configuration
- `MCIF_RD_4K_SPLIT_EN` defined: bursts are additionally clipped so they never cross a 4 KB address boundary (the `atoms_to_4k` term above).
- Undefined: burst = min(`req_left`, 2^LEN_W), and the 4K logic is removed.

## Test plan
Values below use ATOM_BYTES=16 and LEN_W=4 (max burst 16 atoms).
- Split into max bursts: `cmd_addr`=0x1000, `cmd_atoms`=40, `rd_req_rdy`=1 → pd (len_m1,addr) = (15,0x1000), (15,0x1100), (7,0x1200) on 3 consecutive cycles. Return 40 beats with `out_rdy`=1 → 40 `rd_fifo_pop` pulses, then `done` 1 cycle after beat 40.
- 4K split: with `MCIF_RD_4K_SPLIT_EN`, `cmd_addr`=0x0FE0, `cmd_atoms`=8 → (1,0x0FE0), (5,0x1000). Without the macro → (7,0x0FE0) only.
- Request backpressure: hold `rd_req_rdy`=0 for 5 cycles during the first burst → `rd_req_vld`=1 and `rd_req_pd` unchanged for all 5 cycles; sequence completes normally afterwards.
- Client backpressure: `out_rdy`=0 while `rd_resp_vld`=1 → `rd_resp_rdy`=0, `rd_fifo_pop`=0, `beat_left` unchanged. Release → 1 pop per accepted beat.
- Zero length: `cmd_atoms`=0 → no `rd_req_vld`, `busy` high 1 cycle, `done` 1 cycle after the handshake.
- Reset mid-issue: assert `rst_n`=0 after the 2nd burst of a 40-atom command → `rd_req_vld`=0, `busy`=0, `cmd_rdy`=1 after release, and a new command issues from its own address.
